// File: rtl/grf_wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter:
// register address, write-request record and FSM state encoding.
package grf_wb_arbiter_pkg;

    typedef logic [4:0] reg_addr_t;

    typedef struct packed {
        logic [31:0] pc;
        reg_addr_t   addr;
        logic [31:0] data;
    } wr_req_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        STARVE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/grf_wb_fifo.sv
// Long-latency result queue: strict FIFO with per-entry
// destination-address compare outputs for hazard queries.
module grf_wb_fifo
    import grf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_valid,
    input  wr_req_t          push_data,
    output logic             push_ready,
    output wr_req_t          head,
    output logic             head_valid,
    output logic             head_last,
    input  logic             pop,
    input  reg_addr_t        cmp_a1,
    input  reg_addr_t        cmp_a2,
    output logic [DEPTH-1:0] match1,
    output logic [DEPTH-1:0] match2
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    wr_req_t          mem [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign push_ready = (count != CNT_FULL);
    assign head_valid = (count != '0);
    assign head_last  = (count == CNT_ONE);
    assign head       = mem[rptr];
    assign do_push    = push_valid && push_ready;
    assign do_pop     = pop && head_valid;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            match1[i] = vld[i] && (mem[i].addr == cmp_a1);
            match2[i] = vld[i] && (mem[i].addr == cmp_a2);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld   <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                vld[wptr] <= 1'b1;
                wptr      <= wptr + PTR_ONE;
            end
            if (do_pop) begin
                vld[rptr] <= 1'b0;
                rptr      <= rptr + PTR_ONE;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/grf_wb_arbiter.sv
// Register-file write-port arbiter between W stage and a long-latency unit.
// Define GRF_WB_ARBITER_TRACE_EN to print every register-file write.
module grf_wb_arbiter
    import grf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [31:0] lu_pc,
    input  logic [4:0]  lu_addr,
    input  logic [31:0] lu_data,
    output logic        grf_we,
    output logic [4:0]  grf_a3,
    output logic [31:0] grf_wd,
    output logic [31:0] grf_wpc,
    input  logic [4:0]  q_a1,
    input  logic [4:0]  q_a2,
    output logic        q_hit1,
    output logic        q_hit2,
    output logic        freeze_req
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STARVE_LIMIT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    arb_state_t       state;
    logic [CW-1:0]    starve_cnt;
    wr_req_t          lu_req;
    wr_req_t          head;
    logic             head_valid;
    logic             head_last;
    logic [DEPTH-1:0] match1;
    logic [DEPTH-1:0] match2;
    logic             wb_win;
    logic             push;
    logic             enq;
    logic             pop;
    logic             next_empty;

    assign wb_win = wb_valid && (wb_addr != '0);
    assign pop    = head_valid && !wb_win;
    // $0 results are accepted but dropped before reaching the queue
    assign push   = lu_valid && (lu_addr != '0);
    assign enq    = push && lu_ready;
    assign lu_req = '{pc: lu_pc, addr: lu_addr, data: lu_data};

    assign next_empty = !enq && (!head_valid || (head_last && pop));

    grf_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_valid (push),
        .push_data  (lu_req),
        .push_ready (lu_ready),
        .head       (head),
        .head_valid (head_valid),
        .head_last  (head_last),
        .pop        (pop),
        .cmp_a1     (q_a1),
        .cmp_a2     (q_a2),
        .match1     (match1),
        .match2     (match2)
    );

    assign q_hit1 = (q_a1 != '0) && (|match1);
    assign q_hit2 = (q_a2 != '0) && (|match2);

    always_ff @(posedge clk) begin
        if (reset) begin
            grf_we  <= 1'b0;
            grf_a3  <= '0;
            grf_wd  <= '0;
            grf_wpc <= '0;
        end else if (wb_win) begin
            grf_we  <= 1'b1;
            grf_a3  <= wb_addr;
            grf_wd  <= wb_data;
            grf_wpc <= wb_pc;
        end else if (pop) begin
            grf_we  <= 1'b1;
            grf_a3  <= head.addr;
            grf_wd  <= head.data;
            grf_wpc <= head.pc;
        end else begin
            grf_we  <= 1'b0;
            grf_a3  <= '0;
            grf_wd  <= '0;
            grf_wpc <= '0;
        end
    end

    // Starvation tracker; freeze_req is registered alongside the state
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            freeze_req <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    starve_cnt <= '0;
                    freeze_req <= 1'b0;
                    if (enq) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop) begin
                        starve_cnt <= '0;
                        state      <= next_empty ? IDLE : DRAIN;
                    end else if (head_valid) begin
                        starve_cnt <= starve_cnt + CNT_ONE;
                        if (starve_cnt == CNT_LAST) begin
                            state      <= STARVE;
                            freeze_req <= 1'b1;
                        end
                    end
                end
                STARVE: begin
                    if (pop) begin
                        starve_cnt <= '0;
                        freeze_req <= 1'b0;
                        state      <= next_empty ? IDLE : DRAIN;
                    end
                end
                default: begin
                    state      <= IDLE;
                    starve_cnt <= '0;
                    freeze_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef GRF_WB_ARBITER_TRACE_EN
    always @(posedge clk) begin
        if (grf_we) begin
            $display("%d@%h: $%d <= %h", $time, grf_wpc, grf_a3, grf_wd);
        end
    end
`endif

endmodule

// File: doc/grf_wb_arbiter.md
GRF_WB_ARBITER -- requirements
Module: grf_wb_arbiter

Interface
REQ-001 Parameter DEPTH, default 2: long-latency result queue depth, power of two, 2..8.
REQ-002 Parameter STARVE_LIMIT, default 4: consecutive cycles a queued entry may be blocked by writeback before a pipeline freeze is requested.
REQ-003 clk  in  1  clock; all state updates on posedge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 wb_valid  in  1  pipeline W-stage write request; always accepted.
REQ-006 wb_pc / wb_addr / wb_data  in  32/5/32  W-stage PC, destination register, write data.
REQ-007 lu_valid / lu_ready  in/out  1/1  long-latency unit result handshake.
REQ-008 lu_pc / lu_addr / lu_data  in  32/5/32  long-latency result PC, destination register, data.
REQ-009 grf_we / grf_a3 / grf_wd / grf_wpc  out  1/5/32/32  registered drive of the register-file write port.
REQ-010 q_a1 / q_a2  in  5/5  hazard-query read addresses.
REQ-011 q_hit1 / q_hit2  out  1/1  queried register has a pending queued write.
REQ-012 freeze_req  out  1  request that the pipeline hold W (wb_valid low) next cycle.

Function
REQ-013 Enqueue on lu_valid && lu_ready; lu_ready SHALL equal !full, independent of same-cycle dequeue.
REQ-014 Entries with lu_addr == 0 SHALL be accepted and discarded, never enqueued.
REQ-015 Arbitration per cycle: wb_valid with wb_addr != 0 wins; otherwise the queue head, if present, is dequeued.
REQ-016 wb_valid with wb_addr == 0 SHALL NOT produce a write and SHALL leave the port free for the queue.
REQ-017 The winner SHALL appear on grf_* exactly one cycle after selection; grf_we is low in cycles with no winner.
REQ-018 FSM states: IDLE (queue empty), DRAIN (queue non-empty, starve counter < STARVE_LIMIT), STARVE (counter reached STARVE_LIMIT).
REQ-019 In DRAIN, the starve counter SHALL increment each cycle the head loses to writeback and clear on every dequeue.
REQ-020 In STARVE, freeze_req SHALL be high; the pipeline deasserts wb_valid; the head SHALL dequeue in the first cycle with no writeback win; the FSM then returns to DRAIN or IDLE.
REQ-021 If wb_valid is still high in STARVE, writeback still wins and freeze_req stays high.
REQ-022 q_hitN SHALL be combinational: 1 iff q_aN != 0 and q_aN matches any valid queued entry; the entry being dequeued counts until the cycle after selection.
REQ-023 Queue order SHALL be strict FIFO; pointers wrap modulo DEPTH; a full queue with simultaneous enqueue attempt and dequeue accepts nothing that cycle.

Reset
REQ-024 Reset SHALL empty the queue, clear the starve counter, enter IDLE, and drive grf_we=0, grf_a3=0, grf_wd=0, grf_wpc=0, freeze_req=0, lu_ready=1 on the following cycle.
REQ-025 Reset mid-operation SHALL discard queued entries without writing them.

Configuration
REQ-026 Macro GRF_WB_ARBITER_TRACE_EN: when defined, each cycle grf_we is high, print "%d@%h: $%d <= %h" with time, grf_wpc, grf_a3, grf_wd; when undefined, no display statements are compiled.

Structure
REQ-027 The shared package SHALL hold the 5-bit register address type, the write-request record type (pc, addr, data), and the FSM state encoding.
REQ-028 The queue SHALL be a sub-module grf_wb_fifo (parameter DEPTH, valid/ready in, head/pop out, per-entry address compare outputs).

Verification
REQ-029 Reset, then wb_valid=1, addr=5, data=0x1234, pc=0x3000 -> next cycle grf_we=1, a3=5, wd=0x1234, wpc=0x3000.
REQ-030 lu write addr=8, data=0xAA with wb idle -> queued one cycle, q_hit1=1 for q_a1=8, grf write of $8 the following cycle, q_hit1=0 afterward.
REQ-031 Fill queue (DEPTH=2) while wb_valid continuous -> lu_ready=0; freeze_req=1 after 4 blocked cycles; on wb_valid=0, both entries drain in order over 2 cycles.
REQ-032 lu_addr=0 and wb_addr=0 in the same cycle -> no grf_we, queue stays empty, q_hit=0 for q_a=0.
REQ-033 Reset asserted with 2 queued entries -> no grf_we issued, lu_ready=1, state IDLE.
